// File: rtl/bcd_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : bcd_countdown_timer
// Description : N-digit packed-BCD countdown timer for the bomb game. Loads a
//               start time on entry to the run state, counts down on second
//               ticks, subtracts a penalty per strike, freezes on win/lose and
//               flags expiry to the game controller.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_countdown_timer #(
    parameter int unsigned           DIGITS       = 3,
    parameter logic [4*DIGITS-1:0]   DEFAULT_TIME = 12'h200,
    parameter logic [4*DIGITS-1:0]   PENALTY      = 12'h010,
    parameter logic [4*DIGITS-1:0]   WARN_TIME    = 12'h010,
    parameter logic [7:0]            RUN_STATE    = 8'h10,
    parameter logic [7:0]            WIN_STATE    = 8'h20,
    parameter logic [7:0]            LOSE_STATE   = 8'h30
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            game_state,
    input  logic [4*DIGITS-1:0]   init_time,
    input  logic                  sec_tick,
    input  logic                  strike,
    output logic [4*DIGITS-1:0]   time_bcd,
    output logic                  running,
    output logic                  expired,
    output logic                  timed_out,
    output logic                  warn
);

    localparam int unsigned   W    = 4 * DIGITS;
    localparam logic [W-1:0]  ZERO = '0;
    localparam logic [W-1:0]  ONE  = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_FROZEN  = 2'd2,
        S_EXPIRED = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   time_q, time_d;
    logic           running_q, running_d;
    logic           expired_q, expired_d;

    logic [W-1:0]   w_load;
    logic [W-1:0]   w_after_tick;
    logic [W-1:0]   w_after_strike;
    logic           w_end_code;

    // Force every digit into 0..9 so the countdown arithmetic stays legal.
    function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] a);
        logic [W-1:0] r;
        r = a;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (a[4*i +: 4] > 4'd9) begin
                r[4*i +: 4] = 4'd9;
            end
        end
        return r;
    endfunction

    // Digit-serial BCD subtract; a negative digit wraps by +10 and borrows.
    function automatic logic [W-1:0] bcd_sub(input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [W-1:0] r;
        logic         borrow;
        logic [4:0]   diff;
        r      = '0;
        borrow = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            diff = {1'b0, a[4*i +: 4]} - {1'b0, b[4*i +: 4]} - {4'b0000, borrow};
            if (diff[4]) begin
                r[4*i +: 4] = diff[3:0] + 4'd10;
                borrow      = 1'b1;
            end else begin
                r[4*i +: 4] = diff[3:0];
                borrow      = 1'b0;
            end
        end
        return r;
    endfunction

    // Saturating subtract: packed BCD compares correctly as plain binary.
    function automatic logic [W-1:0] sat_sub(input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        return (b >= a) ? ZERO : bcd_sub(a, b);
    endfunction

    // Tick and strike are applied back-to-back, which equals PENALTY+1 with saturation.
    always_comb begin
        w_load         = bcd_clamp(init_time);
        w_after_tick   = sec_tick ? sat_sub(time_q, ONE) : time_q;
        w_after_strike = strike ? sat_sub(w_after_tick, PENALTY) : w_after_tick;
        w_end_code     = (game_state == WIN_STATE) || (game_state == LOSE_STATE);
    end

    // Next-state and next-time decode for the four-state timer FSM.
    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        case (state_q)
            S_IDLE: begin
                time_d = DEFAULT_TIME;
                if (game_state == RUN_STATE) begin
                    if (w_load == ZERO) begin
                        state_d = S_EXPIRED;
                        time_d  = ZERO;
                    end else begin
                        state_d = S_RUN;
                        time_d  = w_load;
                    end
                end
            end
            S_RUN: begin
                if (game_state == RUN_STATE) begin
                    if (sec_tick || strike) begin
                        time_d = w_after_strike;
                        if (w_after_strike == ZERO) begin
                            state_d = S_EXPIRED;
                        end
                    end
                end else if (w_end_code) begin
                    state_d = S_FROZEN;
                end
            end
            S_FROZEN: begin
                if (!w_end_code) begin
                    state_d = S_IDLE;
                    time_d  = DEFAULT_TIME;
                end
            end
            S_EXPIRED: begin
                time_d = ZERO;
                if (game_state != RUN_STATE) begin
                    state_d = S_IDLE;
                    time_d  = DEFAULT_TIME;
                end
            end
            default: begin
                state_d = S_IDLE;
                time_d  = DEFAULT_TIME;
            end
        endcase
        running_d = (state_d == S_RUN);
        expired_d = (state_d == S_EXPIRED) && (state_q != S_EXPIRED);
    end

    // State, time and flag registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            time_q    <= DEFAULT_TIME;
            running_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            time_q    <= time_d;
            running_q <= running_d;
            expired_q <= expired_d;
        end
    end

    assign time_bcd  = time_q;
    assign running   = running_q;
    assign expired   = expired_q;
    assign timed_out = (state_q == S_EXPIRED);
    assign warn      = running_q && (time_q < WARN_TIME);

endmodule
`default_nettype wire

// File: tb/tb_bcd_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_countdown_timer
// Description : Self-checking bench for bcd_countdown_timer (default params).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_countdown_timer;

    logic        clk;
    logic        reset;
    logic [7:0]  game_state;
    logic [11:0] init_time;
    logic        sec_tick;
    logic        strike;
    logic [11:0] time_bcd;
    logic        running;
    logic        expired;
    logic        timed_out;
    logic        warn;

    int checks   = 0;
    int failures = 0;

    bcd_countdown_timer dut (
        .clk        (clk),
        .reset      (reset),
        .game_state (game_state),
        .init_time  (init_time),
        .sec_tick   (sec_tick),
        .strike     (strike),
        .time_bcd   (time_bcd),
        .running    (running),
        .expired    (expired),
        .timed_out  (timed_out),
        .warn       (warn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  gs;
        logic        tk;
        logic        st;
        logic [11:0] init;
        logic [11:0] t;
        logic        run;
        logic        ex;
        logic        to;
        logic        wn;
    } vec_t;

    localparam int NV = 31;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic [7:0] gs, input logic tk, input logic st,
                                input logic [11:0] init, input logic [11:0] t,
                                input logic run, input logic ex, input logic to,
                                input logic wn);
        vec_t v;
        v.gs = gs; v.tk = tk; v.st = st; v.init = init; v.t = t;
        v.run = run; v.ex = ex; v.to = to; v.wn = wn;
        return v;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic [11:0] t, input logic run,
                           input logic ex, input logic to, input logic wn);
        chk("time_bcd",  idx, {4'h0, time_bcd},   {4'h0, t});
        chk("running",   idx, {15'h0, running},   {15'h0, run});
        chk("expired",   idx, {15'h0, expired},   {15'h0, ex});
        chk("timed_out", idx, {15'h0, timed_out}, {15'h0, to});
        chk("warn",      idx, {15'h0, warn},      {15'h0, wn});
    endtask

    initial begin
        //                gs     tk    st    init     time    run ex to wn
        vecs[0]  = mk(8'h10, 1'b0, 1'b0, 12'h100, 12'h100, 1, 0, 0, 0);
        vecs[1]  = mk(8'h10, 1'b1, 1'b0, 12'h000, 12'h099, 1, 0, 0, 0);
        vecs[2]  = mk(8'h10, 1'b1, 1'b0, 12'h000, 12'h098, 1, 0, 0, 0);
        vecs[3]  = mk(8'h10, 1'b1, 1'b0, 12'h000, 12'h097, 1, 0, 0, 0);
        vecs[4]  = mk(8'h10, 1'b0, 1'b1, 12'h000, 12'h087, 1, 0, 0, 0);
        vecs[5]  = mk(8'h10, 1'b1, 1'b1, 12'h000, 12'h076, 1, 0, 0, 0);
        vecs[6]  = mk(8'h07, 1'b1, 1'b1, 12'h000, 12'h076, 1, 0, 0, 0);
        vecs[7]  = mk(8'h20, 1'b1, 1'b0, 12'h000, 12'h076, 0, 0, 0, 0);
        vecs[8]  = mk(8'h20, 1'b1, 1'b0, 12'h000, 12'h076, 0, 0, 0, 0);
        vecs[9]  = mk(8'h30, 1'b1, 1'b1, 12'h000, 12'h076, 0, 0, 0, 0);
        vecs[10] = mk(8'h05, 1'b0, 1'b0, 12'h000, 12'h200, 0, 0, 0, 0);
        vecs[11] = mk(8'h10, 1'b0, 1'b0, 12'h0FA, 12'h099, 1, 0, 0, 0);
        vecs[12] = mk(8'h30, 1'b0, 1'b0, 12'h000, 12'h099, 0, 0, 0, 0);
        vecs[13] = mk(8'h00, 1'b0, 1'b0, 12'h000, 12'h200, 0, 0, 0, 0);
        vecs[14] = mk(8'h10, 1'b0, 1'b0, 12'h000, 12'h000, 0, 1, 1, 0);
        vecs[15] = mk(8'h10, 1'b1, 1'b0, 12'h000, 12'h000, 0, 0, 1, 0);
        vecs[16] = mk(8'h00, 1'b0, 1'b0, 12'h000, 12'h200, 0, 0, 0, 0);
        vecs[17] = mk(8'h10, 1'b0, 1'b0, 12'h005, 12'h005, 1, 0, 0, 1);
        vecs[18] = mk(8'h10, 1'b0, 1'b1, 12'h000, 12'h000, 0, 1, 1, 0);
        vecs[19] = mk(8'h10, 1'b0, 1'b0, 12'h000, 12'h000, 0, 0, 1, 0);
        vecs[20] = mk(8'h00, 1'b0, 1'b0, 12'h000, 12'h200, 0, 0, 0, 0);
        vecs[21] = mk(8'h10, 1'b0, 1'b0, 12'h011, 12'h011, 1, 0, 0, 0);
        vecs[22] = mk(8'h10, 1'b1, 1'b0, 12'h000, 12'h010, 1, 0, 0, 0);
        vecs[23] = mk(8'h10, 1'b1, 1'b0, 12'h000, 12'h009, 1, 0, 0, 1);
        vecs[24] = mk(8'h10, 1'b1, 1'b1, 12'h000, 12'h000, 0, 1, 1, 0);
        vecs[25] = mk(8'h00, 1'b0, 1'b0, 12'h000, 12'h200, 0, 0, 0, 0);
        vecs[26] = mk(8'h10, 1'b0, 1'b0, 12'h120, 12'h120, 1, 0, 0, 0);
        vecs[27] = mk(8'h10, 1'b1, 1'b1, 12'h000, 12'h109, 1, 0, 0, 0);
        vecs[28] = mk(8'h20, 1'b0, 1'b0, 12'h000, 12'h109, 0, 0, 0, 0);
        vecs[29] = mk(8'h00, 1'b0, 1'b0, 12'h000, 12'h200, 0, 0, 0, 0);
        vecs[30] = mk(8'h00, 1'b1, 1'b1, 12'h000, 12'h200, 0, 0, 0, 0);

        // Reset held low for two clocks
        reset      = 1'b0;
        game_state = 8'h00;
        init_time  = 12'h000;
        sec_tick   = 1'b0;
        strike     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all(-1, 12'h200, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;

        // Table-driven single-cycle vectors
        for (int i = 0; i < NV; i++) begin
            game_state = vecs[i].gs;
            sec_tick   = vecs[i].tk;
            strike     = vecs[i].st;
            init_time  = vecs[i].init;
            @(posedge clk);
            #1;
            chk_all(i, vecs[i].t, vecs[i].run, vecs[i].ex, vecs[i].to, vecs[i].wn);
        end
        sec_tick = 1'b0;
        strike   = 1'b0;

        // Reset asserted mid-run while a fatal strike is pending: no expiry
        game_state = 8'h10;
        init_time  = 12'h005;
        @(posedge clk);
        #1;
        chk_all(100, 12'h005, 1'b1, 1'b0, 1'b0, 1'b1);
        reset  = 1'b0;
        strike = 1'b1;
        @(posedge clk);
        #1;
        chk_all(101, 12'h200, 1'b0, 1'b0, 1'b0, 1'b0);
        strike = 1'b0;
        @(posedge clk);
        #1;
        chk_all(102, 12'h200, 1'b0, 1'b0, 1'b0, 1'b0);
        reset      = 1'b1;
        game_state = 8'h00;
        @(posedge clk);
        #1;
        chk_all(103, 12'h200, 1'b0, 1'b0, 1'b0, 1'b0);

        // Expired pulse lasts one cycle while timed_out holds
        game_state = 8'h10;
        init_time  = 12'h001;
        @(posedge clk);
        #1;
        chk_all(110, 12'h001, 1'b1, 1'b0, 1'b0, 1'b1);
        sec_tick = 1'b1;
        @(posedge clk);
        #1;
        chk_all(111, 12'h000, 1'b0, 1'b1, 1'b1, 1'b0);
        sec_tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all(112, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0);
        game_state = 8'h00;
        @(posedge clk);
        #1;
        chk_all(113, 12'h200, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
